// File: rtl/request_unit_ctrl.sv
// rtl/request_unit_ctrl.sv - request unit: registered dmem requests, PC gating, halt, watchdog, statistics
module request_unit_ctrl #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             iREN,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcWEN,
    output logic             busy,
    output logic             err,
    output logic             halted,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0] dreq_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DPEND = 2'd1,
        HALT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             dren_q, dren_d;
    logic             dwen_q, dwen_d;
    logic             err_q, err_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] dreq_q, dreq_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            wait_q   <= '0;
            dreq_q   <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            dren_q   <= dren_d;
            dwen_q   <= dwen_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
            dreq_q   <= dreq_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        err_d    = err_q;
        halted_d = halted_q;
        wait_d   = wait_q;
        dreq_d   = dreq_q;
        wd_d     = wd_q;
        pcWEN    = 1'b0;
        case (state_q)
            IDLE: begin
                pcWEN = ihit & ~dREN & ~dWEN & ~halt;
                // The decoding ihit launches the request; any dhit here is spurious.
                if (ihit) begin
                    if (dREN && dWEN) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (halt) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else if (dREN || dWEN) begin
                        state_d = DPEND;
                        dren_d  = dREN;
                        dwen_d  = dWEN;
                        wd_d    = '0;
                    end
                end
            end
            DPEND: begin
                pcWEN = dhit;
                if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + CNT_ONE;
                end
                // A hit on the timeout cycle still completes the transaction.
                if (dhit) begin
                    state_d = IDLE;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    dreq_d  = dreq_q + CNT_ONE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                end else begin
                    wd_d = wd_q + CNT_ONE;
                end
            end
            default: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
            end
        endcase
    end

    assign imemREN  = iREN & ((state_q == IDLE) | (state_q == DPEND));
    assign dmemREN  = dren_q;
    assign dmemWEN  = dwen_q;
    assign busy     = (state_q == DPEND);
    assign err      = err_q;
    assign halted   = halted_q;
    assign wait_cnt = wait_q;
    assign dreq_cnt = dreq_q;

endmodule

// File: tb/tb_request_unit_ctrl.sv
// tb/tb_request_unit_ctrl.sv - self-checking bench for request_unit_ctrl against a transaction-level model
module tb_request_unit_ctrl;

    logic CLK, nRST;
    logic ihit, dhit, iREN, dREN, dWEN, halt;

    logic       imem_a, dren_a, dwen_a, pc_a, busy_a, err_a, halt_a;
    logic [7:0] wait_a, dreq_a;
    logic       imem_b, dren_b, dwen_b, pc_b, busy_b, err_b, halt_b;
    logic [1:0] wait_b, dreq_b;

    int n_pass  = 0;
    int n_total = 0;

    request_unit_ctrl #(.CNT_W(8), .TIMEOUT(4)) dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .iREN(iREN),
        .dREN(dREN), .dWEN(dWEN), .halt(halt),
        .imemREN(imem_a), .dmemREN(dren_a), .dmemWEN(dwen_a), .pcWEN(pc_a),
        .busy(busy_a), .err(err_a), .halted(halt_a),
        .wait_cnt(wait_a), .dreq_cnt(dreq_a)
    );

    request_unit_ctrl #(.CNT_W(2), .TIMEOUT(3)) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .iREN(iREN),
        .dREN(dREN), .dWEN(dWEN), .halt(halt),
        .imemREN(imem_b), .dmemREN(dren_b), .dmemWEN(dwen_b), .pcWEN(pc_b),
        .busy(busy_b), .err(err_b), .halted(halt_b),
        .wait_cnt(wait_b), .dreq_cnt(dreq_b)
    );

    logic [22:0] obs_w [2];
    assign obs_w[0] = {imem_a, dren_a, dwen_a, pc_a, busy_a, err_a, halt_a, wait_a, dreq_a};
    assign obs_w[1] = {imem_b, dren_b, dwen_b, pc_b, busy_b, err_b, halt_b,
                       6'd0, wait_b, 6'd0, dreq_b};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: one outstanding transaction, its age, terminal flags, and plain-integer statistics.
    int p_timeout [2] = '{4, 3};
    int p_max     [2] = '{255, 3};
    int p_mod     [2] = '{256, 4};
    int m_pend [2], m_rd [2], m_wr [2], m_age [2];
    int m_err  [2], m_halt [2], m_wait [2], m_dreq [2];

    always @(posedge CLK or negedge nRST) begin
        for (int k = 0; k < 2; k++) begin
            if (!nRST) begin
                m_pend[k] = 0; m_rd[k] = 0; m_wr[k] = 0; m_age[k] = 0;
                m_err[k]  = 0; m_halt[k] = 0; m_wait[k] = 0; m_dreq[k] = 0;
            end else if (m_err[k] != 0 || m_halt[k] != 0) begin
                m_pend[k] = 0;
            end else if (m_pend[k] != 0) begin
                m_wait[k] = (m_wait[k] + 1 > p_max[k]) ? p_max[k] : m_wait[k] + 1;
                if (dhit) begin
                    m_pend[k] = 0;
                    m_dreq[k] = (m_dreq[k] + 1) % p_mod[k];
                end else if (m_age[k] + 1 >= p_timeout[k]) begin
                    m_pend[k] = 0;
                    m_err[k]  = 1;
                end else begin
                    m_age[k] = m_age[k] + 1;
                end
            end else if (ihit) begin
                if (dREN && dWEN) m_err[k] = 1;
                else if (halt) m_halt[k] = 1;
                else if (dREN || dWEN) begin
                    m_pend[k] = 1; m_rd[k] = int'(dREN); m_wr[k] = int'(dWEN); m_age[k] = 0;
                end
            end
        end
    end

    function automatic logic [22:0] exp_w(int k);
        logic dead, pc;
        dead = (m_err[k] != 0) || (m_halt[k] != 0);
        if (dead) pc = 1'b0;
        else if (m_pend[k] != 0) pc = dhit;
        else pc = ihit && !dREN && !dWEN && !halt;
        return {iREN && !dead, (m_pend[k] != 0) && (m_rd[k] != 0), (m_pend[k] != 0) && (m_wr[k] != 0),
                pc, m_pend[k] != 0, m_err[k] != 0, m_halt[k] != 0,
                8'(m_wait[k]), 8'(m_dreq[k])};
    endfunction

    // Vector order: {ihit, dhit, iREN, dREN, dWEN, halt}
    task automatic drive(input logic [5:0] v);
        @(negedge CLK);
        {ihit, dhit, iREN, dREN, dWEN, halt} = v;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        {ihit, dhit, iREN, dREN, dWEN, halt} = 6'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        {ihit, dhit, iREN, dREN, dWEN, halt} = 6'b0;
        repeat (2) @(negedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (obs_w[k] !== exp_w(k) || obs_w[k] !== 23'd0)
                $display("FAIL reset dut%0d: got %h want %h", k, obs_w[k], 23'd0);
            else n_pass++;
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_plain_fetch();
        for (int i = 0; i < 3; i++) begin
            drive(6'b101000);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs_w[k] !== exp_w(k) || !obs_w[k][19])
                    $display("FAIL fetch dut%0d step%0d: got %h want %h", k, i, obs_w[k], exp_w(k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_load();
        logic [5:0] seq [$];
        seq = '{6'b111100, 6'b001000, 6'b001000, 6'b011000, 6'b001000, 6'b011000};
        do_reset();
        foreach (seq[i]) begin
            drive(seq[i]);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs_w[k] !== exp_w(k))
                    $display("FAIL load dut%0d step%0d: got %h want %h", k, i, obs_w[k], exp_w(k));
                else n_pass++;
            end
        end
        n_total++;
        if (dreq_a !== 8'd1 || wait_a !== 8'd3)
            $display("FAIL load_counts: got wait %0d dreq %0d want wait 3 dreq 1", wait_a, dreq_a);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [5:0] seq [$];
        seq = '{6'b101010, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000,
                6'b111000, 6'b111010};
        do_reset();
        foreach (seq[i]) begin
            drive(seq[i]);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs_w[k] !== exp_w(k))
                    $display("FAIL timeout dut%0d step%0d: got %h want %h", k, i, obs_w[k], exp_w(k));
                else n_pass++;
            end
        end
        n_total++;
        if (err_a !== 1'b1 || dreq_a !== 8'd0 || wait_a !== 8'd4)
            $display("FAIL timeout_final: got err %b dreq %0d wait %0d want 1 0 4", err_a, dreq_a, wait_a);
        else n_pass++;
    endtask

    task automatic test_conflict_and_halt();
        logic [5:0] seq [$];
        for (int t = 0; t < 2; t++) begin
            seq = (t == 0) ? '{6'b101110, 6'b111010, 6'b101100}
                           : '{6'b101001, 6'b101100, 6'b111010};
            do_reset();
            foreach (seq[i]) begin
                drive(seq[i]);
                for (int k = 0; k < 2; k++) begin
                    n_total++;
                    if (obs_w[k] !== exp_w(k))
                        $display("FAIL terminal%0d dut%0d step%0d: got %h want %h",
                                 t, k, i, obs_w[k], exp_w(k));
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (halt_a !== 1'b1 || imem_a !== 1'b0 || dren_a !== 1'b0)
            $display("FAIL halt_final: got halted %b imem %b dren %b want 1 0 0", halt_a, imem_a, dren_a);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            case (i % 3)
                0:       drive(6'b101100);
                1:       drive(6'b001000);
                default: drive(6'b011000);
            endcase
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs_w[k] !== exp_w(k))
                    $display("FAIL wrap dut%0d step%0d: got %h want %h", k, i, obs_w[k], exp_w(k));
                else n_pass++;
            end
        end
        drive(6'b000000);
        n_total++;
        if (dreq_b !== 2'd1 || wait_b !== 2'd3 || dreq_a !== 8'd5 || wait_a !== 8'd10)
            $display("FAIL wrap_counts: got b %0d/%0d a %0d/%0d want 1/3 5/10",
                     dreq_b, wait_b, dreq_a, wait_a);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(6'b101100);
        drive(6'b001000);
        n_total++;
        if (dren_a !== 1'b1 || dren_b !== 1'b1)
            $display("FAIL async_pre: got dren %b%b want 11", dren_a, dren_b);
        else n_pass++;
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (obs_w[k] !== exp_w(k) || obs_w[k][21:16] !== 6'd0)
                $display("FAIL async_clear dut%0d: got %h want %h", k, obs_w[k], exp_w(k));
            else n_pass++;
        end
        @(negedge CLK);
        nRST = 1'b1;
        drive(6'b101000);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (obs_w[k] !== exp_w(k) || !obs_w[k][19])
                $display("FAIL async_after dut%0d: got %h want %h", k, obs_w[k], exp_w(k));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [5:0] v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_pend[0] == 0 && m_pend[1] == 0 &&
                (m_err[0] != 0 || m_halt[0] != 0) && (m_err[1] != 0 || m_halt[1] != 0))
                do_reset();
            v[5] = ($urandom % 2) == 0;
            v[4] = ($urandom % 3) == 0;
            v[3] = ($urandom % 4) != 0;
            v[2] = ($urandom % 4) == 0;
            v[1] = ($urandom % 4) == 0;
            v[0] = ($urandom % 20) == 0;
            drive(v);
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (obs_w[k] !== exp_w(k))
                    $display("FAIL random dut%0d step%0d in %b: got %h want %h",
                             k, i, v, obs_w[k], exp_w(k));
                else n_pass++;
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        {ihit, dhit, iREN, dREN, dWEN, halt} = 6'b0;
        test_reset();
        test_plain_fetch();
        test_load();
        test_timeout();
        test_conflict_and_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/request_unit_ctrl.md
Name: request_unit_ctrl

Overview:
Parametrised request unit for the single-cycle MIPS datapath. It sits between the control/decode logic and the memory-request outputs. Its jobs:
- Hold data-memory read/write requests as registered levels until the memory reports a hit.
- Gate PC advance on instruction and data completion.
- Suppress instruction fetch after halt.
- Run a watchdog on stalled data requests.
- Keep transaction and wait-cycle statistics.

Parameters:
CNT_W, 8, width of wait_cnt, dreq_cnt and the watchdog counter.
TIMEOUT, 200, maximum cycles a data request may stay pending before an error is raised. Legal range 1..2^CNT_W-1.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction memory hit this cycle.
dhit  in  1  data memory hit this cycle.
iREN  in  1  fetch request from control.
dREN  in  1  decoded instruction is a load.
dWEN  in  1  decoded instruction is a store.
halt  in  1  decoded instruction is halt.
imemREN  out  1  instruction memory read enable.
dmemREN  out  1  data memory read enable, registered.
dmemWEN  out  1  data memory write enable, registered.
pcWEN  out  1  PC write enable, combinational.
busy  out  1  data request pending.
err  out  1  sticky error flag.
halted  out  1  sticky halt flag.
wait_cnt  out  CNT_W  saturating count of all cycles spent in DPEND.
dreq_cnt  out  CNT_W  wrapping count of completed data transactions.

Behaviour:
- Reset (asynchronous, nRST low). State goes to IDLE. dmemREN, dmemWEN, busy, err, halted, wait_cnt, dreq_cnt and the watchdog counter all go to 0. Reset asserted mid-transaction drops any pending request immediately.
- States: IDLE, DPEND, HALT, ERR.
- IDLE, on ihit, in priority order:
  - dREN&dWEN: go to ERR, err<=1.
  - else halt: go to HALT, halted<=1.
  - else dREN|dWEN: go to DPEND, dmemREN<=dREN, dmemWEN<=dWEN, watchdog<=0.
  - else: stay in IDLE.
- IDLE, no ihit: stay in IDLE. dhit is ignored (spurious).
- DPEND:
  - On dhit: clear dmemREN/dmemWEN, go to IDLE, dreq_cnt<=dreq_cnt+1 (wraps).
  - Otherwise: watchdog increments. When watchdog==TIMEOUT-1 without dhit, go to ERR, err<=1, clear dmemREN/dmemWEN. dreq_cnt is not incremented.
  - Every DPEND cycle: wait_cnt increments, saturating at all-ones.
  - ihit is ignored in DPEND.
- HALT and ERR are terminal until reset. Outputs there: dmem* = 0, pcWEN = 0, imemREN = 0.
- pcWEN (combinational):
  - IDLE: ihit & ~dREN & ~dWEN & ~halt.
  - DPEND: dhit.
  - All other states: 0.
- imemREN = iREN & (state==IDLE | state==DPEND).
- busy = (state==DPEND).
- Data requests go out one cycle after the decoding ihit. A dhit in that same ihit cycle is not a completion.
- dhit and the timeout on the same cycle: dhit wins, so the transaction completes normally.

Test Plan:
- Reset, then ihit=1 with no data op for 3 cycles -> pcWEN=1 each cycle, dmemREN=dmemWEN=0, dreq_cnt=0.
- ihit+dREN=1, dhit asserted 3 cycles later -> dmemREN=1 for 3 cycles, busy=1, pcWEN=1 only on the dhit cycle, wait_cnt=3, dreq_cnt=1.
- TIMEOUT=4, ihit+dWEN, dhit never arrives -> dmemWEN high for 4 cycles then 0, err=1, pcWEN stays 0; a later dhit has no effect.
- ihit+dREN+dWEN together -> ERR, err=1, no dmem request issued. Separately, ihit+halt -> halted=1, imemREN=0 despite iREN=1.
- CNT_W=2: five loads each completed by dhit -> dreq_cnt wraps to 1; wait_cnt saturates at 3.
- Assert nRST low for one cycle while dmemREN=1 -> outputs clear asynchronously, before the next clock edge; after release, state is IDLE and pcWEN follows ihit.
